// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative shift-add
// multiplier and restoring divider sharing one 2*WIDTH working register.
module iter_alu #(
    parameter int WIDTH     = 32,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALU_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      counter;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] prod_q, prod_next;
    logic               accept, start_muldiv, last_step;

    logic [WIDTH-1:0]   add_sum, sub_diff, alu_res, md_res, div_diff;
    logic               add_ovf, sub_ovf, alu_ovf, div_ge;
    logic [WIDTH:0]     mul_sum, div_shift;

    assign start_muldiv = EN_MULDIV && (ALU_ctl[3:2] == 2'b10);
    assign last_step    = (state == BUSY) && (counter == CW'(1));
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
        accept = in_valid & in_ready;
        case (state)
            IDLE: if (accept) state_next = start_muldiv ? BUSY : DONE;
            BUSY: if (last_step) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? (start_muldiv ? BUSY : DONE) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ops evaluate straight from the incoming operands at accept.
    assign add_sum  = a + b;
    assign sub_diff = a - b;
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        alu_res = a & b;
        alu_ovf = 1'b0;
        case (ALU_ctl)
            4'b0001: alu_res = a | b;
            4'b0010: begin alu_res = add_sum;  alu_ovf = add_ovf; end
            4'b0110: begin alu_res = sub_diff; alu_ovf = sub_ovf; end
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH-1] ^ sub_ovf};
            4'b1100: alu_res = ~(a | b);
            default: alu_res = a & b;
        endcase
    end

    // Upper half holds accumulator/remainder, lower half multiplier/quotient.
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign prod_next = op_q[1] ? {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge}
                               : {mul_sum, prod_q[WIDTH-1:1]};
    assign md_res    = op_q[0] ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= ALU_ctl[1:0];
            counter <= CW'(WIDTH);
            prod_q  <= {{WIDTH{1'b0}}, (ALU_ctl[1] ? a : b)};
            if (!start_muldiv) begin
                result   <= alu_res;
                zero     <= (alu_res == '0);
                overflow <= alu_ovf;
            end
        end else if (state == BUSY) begin
            prod_q  <= prod_next;
            counter <= counter - CW'(1);
            if (last_step) begin
                result   <= md_res;
                zero     <= (md_res == '0);
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32): directed cases plus random ops
// compared against an arithmetic reference model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  ALU_ctl;
    logic        in_ready, out_valid, zero, overflow, busy;

    int checks = 0;
    int errors = 0;

    localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINS = -64'sh0000_0000_8000_0000;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32), .EN_MULDIV(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALU_ctl(ALU_ctl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy)
    );

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic void ref_model(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output logic v, output int lat);
        longint sx, sy, s;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        p = {32'b0, x} * {32'b0, y};
        v = 1'b0;
        lat = 1;
        case (ctl)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin s = sx + sy; r = x + y; v = (s > MAXS) || (s < MINS); end
            4'b0110: begin s = sx - sy; r = x - y; v = (s > MAXS) || (s < MINS); end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: r = ~(x | y);
            4'b1000: begin r = p[31:0];  lat = 33; end
            4'b1001: begin r = p[63:32]; lat = 33; end
            4'b1010: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = 33; end
            4'b1011: begin r = (y == 0) ? x : x % y; lat = 33; end
            default: r = x & y;
        endcase
    endfunction

    // Drives one op from a negedge, waits for accept, then for out_valid.
    // Returns at the negedge where out_valid is first seen.
    task automatic applyStimulus(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y,
                                 output int lat, output bit busy_ok,
                                 output logic [31:0] r, output logic z, output logic v);
        int n;
        ALU_ctl = ctl; a = x; b = y; in_valid = 1'b1;
        n = 0; lat = -1; busy_ok = 1'b0; r = 'x; z = 1'bx; v = 1'bx;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout got in_ready=%b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("[TB] FAIL result_timeout got out_valid=%b want 1", out_valid);
            return;
        end
        r = result; z = zero; v = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ALU_ctl = '0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        checks++; if (result !== 32'h0)   begin errors++; $display("[TB] FAIL rst_result got %h want 0", result); end
        checks++; if (zero !== 1'b0)      begin errors++; $display("[TB] FAIL rst_zero got %b want 0", zero); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("[TB] FAIL rst_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_sub();
        int lat; bit bok; logic [31:0] r; logic z, v;
        @(negedge clk);
        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1, lat, bok, r, z, v);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result got %h want 80000000", r); end
        checks++; if (v !== 1'b1)          begin errors++; $display("[TB] FAIL add_overflow got %b want 1", v); end
        checks++; if (lat != 1)            begin errors++; $display("[TB] FAIL add_latency got %0d want 1", lat); end
        applyStimulus(4'b0110, 32'd5, 32'd5, lat, bok, r, z, v);
        checks++; if (r !== 32'h0)         begin errors++; $display("[TB] FAIL sub_result got %h want 0", r); end
        checks++; if (z !== 1'b1)          begin errors++; $display("[TB] FAIL sub_zero got %b want 1", z); end
        checks++; if (v !== 1'b0)          begin errors++; $display("[TB] FAIL sub_overflow got %b want 0", v); end
    endtask

    task automatic test_logic();
        int lat; bit bok; logic [31:0] r; logic z, v;
        @(negedge clk);
        applyStimulus(4'b0111, 32'h8000_0000, 32'h1, lat, bok, r, z, v);
        checks++; if (r !== 32'h1)         begin errors++; $display("[TB] FAIL slt_result got %h want 1", r); end
        applyStimulus(4'b1100, 32'h0, 32'h0, lat, bok, r, z, v);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL nor_result got %h want ffffffff", r); end
        applyStimulus(4'b0101, 32'hF0, 32'h3C, lat, bok, r, z, v);
        checks++; if (r !== 32'h30)        begin errors++; $display("[TB] FAIL undef_result got %h want 30", r); end
    endtask

    task automatic test_mul();
        int lat; bit bok; logic [31:0] r; logic z, v;
        @(negedge clk);
        applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'h2, lat, bok, r, z, v);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mul_result got %h want fffffffe", r); end
        applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'h2, lat, bok, r, z, v);
        checks++; if (r !== 32'h1)         begin errors++; $display("[TB] FAIL mulhu_result got %h want 1", r); end
        checks++; if (lat != 33)           begin errors++; $display("[TB] FAIL mulhu_latency got %0d want 33", lat); end
        checks++; if (bok !== 1'b1)        begin errors++; $display("[TB] FAIL mulhu_busy got %b want 1", bok); end
    endtask

    task automatic test_div();
        int lat; bit bok; logic [31:0] r; logic z, v;
        @(negedge clk);
        applyStimulus(4'b1010, 32'd100, 32'd7, lat, bok, r, z, v);
        checks++; if (r !== 32'd14)        begin errors++; $display("[TB] FAIL divu_result got %h want e", r); end
        applyStimulus(4'b1011, 32'd100, 32'd7, lat, bok, r, z, v);
        checks++; if (r !== 32'd2)         begin errors++; $display("[TB] FAIL remu_result got %h want 2", r); end
        applyStimulus(4'b1010, 32'd9, 32'd0, lat, bok, r, z, v);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu0_result got %h want ffffffff", r); end
        checks++; if (lat != 33)           begin errors++; $display("[TB] FAIL divu0_latency got %0d want 33", lat); end
        applyStimulus(4'b1011, 32'd9, 32'd0, lat, bok, r, z, v);
        checks++; if (r !== 32'd9)         begin errors++; $display("[TB] FAIL remu0_result got %h want 9", r); end
    endtask

    task automatic test_back_to_back();
        int lat, elat; bit bok; logic [31:0] r, er, x, y; logic z, v, ev;
        logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom;
            ref_model(codes[i], x, y, er, ev, elat);
            applyStimulus(codes[i], x, y, lat, bok, r, z, v);
            checks++; if (r !== er)  begin errors++; $display("[TB] FAIL b2b_result[%0d] got %h want %h", i, r, er); end
            checks++; if (lat != 1)  begin errors++; $display("[TB] FAIL b2b_latency[%0d] got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_random();
        int lat, elat; bit bok; logic [31:0] r, er, x, y; logic z, v, ev; logic [3:0] ctl;
        logic [3:0] codes [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000,
                                   4'b1001, 4'b1010, 4'b1011, 4'b0101, 4'b0011, 4'b1111};
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            ctl = codes[$urandom_range(0, 12)];
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            ref_model(ctl, x, y, er, ev, elat);
            applyStimulus(ctl, x, y, lat, bok, r, z, v);
            checks++; if (r !== er)   begin errors++; $display("[TB] FAIL rnd_result[%0d] op %b a %h b %h got %h want %h", i, ctl, x, y, r, er); end
            checks++; if (z !== (er == 32'h0)) begin errors++; $display("[TB] FAIL rnd_zero[%0d] got %b want %b", i, z, (er == 32'h0)); end
            checks++; if (v !== ev)   begin errors++; $display("[TB] FAIL rnd_overflow[%0d] got %b want %b", i, v, ev); end
            checks++; if (lat != elat) begin errors++; $display("[TB] FAIL rnd_latency[%0d] got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_stall();
        int lat, elat; bit bok; logic [31:0] r, er, ar, x, y; logic z, v, ev;
        @(negedge clk);
        out_ready = 1'b0;
        x = $urandom; y = $urandom;
        ref_model(4'b1000, x, y, er, ev, elat);
        applyStimulus(4'b1000, x, y, lat, bok, r, z, v);
        checks++; if (r !== er) begin errors++; $display("[TB] FAIL stall_mul_result got %h want %h", r, er); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (result !== er)     begin errors++; $display("[TB] FAIL stall_hold[%0d] got %h want %h", i, result, er); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
        end
        x = $urandom; y = $urandom;
        ref_model(4'b0010, x, y, ar, ev, elat);
        out_ready = 1'b1; in_valid = 1'b1; ALU_ctl = 4'b0010; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL resume_valid got %b want 1", out_valid); end
        checks++; if (result !== ar)      begin errors++; $display("[TB] FAIL resume_result got %h want %h", result, ar); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; logic [31:0] r; logic z, v; bit seen;
        @(negedge clk);
        applyStimulus(4'b0010, 32'd1, 32'd1, lat, bok, r, z, v);
        ALU_ctl = 4'b1010; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (result !== 32'h0)   begin errors++; $display("[TB] FAIL mid_rst_result got %h want 0", result); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL mid_rst_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_discard got out_valid=1 want 0"); end
        applyStimulus(4'b0010, 32'd2, 32'd3, lat, bok, r, z, v);
        checks++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL post_rst_add got %h want 5", r); end
        checks++; if (lat != 1)    begin errors++; $display("[TB] FAIL post_rst_latency got %0d want 1", lat); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_mul();
        test_div();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
